// File: rtl/bist_ctrl.sv
// bist_ctrl: LBIST sequencer and result collector.
//
// Seeds the test pattern generator, steps it through N_PAT patterns while the
// CUT input mux is in test mode, then waits LAT cycles for the trailing ORA
// results before reporting a verdict.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       run request, honoured only in IDLE or DONE
//   ora_res     ORA result bit, 1 = mismatch
//   tpg_load    one-cycle TPG seed load pulse
//   tpg_en      TPG advance, one pattern per cycle
//   bist_mode   selects TPG patterns into the CUT
//   busy        high while SEED, RUN or DRAIN
//   done        high in DONE
//   pass        done and no mismatches seen
//   fail_cnt    saturating count of mismatching samples
//   first_fail  sample index of the first mismatch, all-ones if none
module bist_ctrl #(
    parameter int BIT   = 4,
    parameter int N_PAT = 2**BIT - 1,
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ora_res,
    output logic             tpg_load,
    output logic             tpg_en,
    output logic             bist_mode,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail
);

    localparam int PAT_W = (N_PAT > 1) ? $clog2(N_PAT) : 1;
    localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [PAT_W-1:0]   pat_cnt_reg, pat_cnt_next;
    logic [LAT_W-1:0]   lat_cnt_reg, lat_cnt_next;
    logic               clr;

    logic [LAT-1:0]     vld_reg;
    logic               sample;

    logic [CNT_W-1:0]   fail_cnt_reg;
    logic [CNT_W-1:0]   first_fail_reg;
    logic [CNT_W-1:0]   smp_idx_reg;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            pat_cnt_reg <= '0;
            lat_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pat_cnt_reg <= pat_cnt_next;
            lat_cnt_reg <= lat_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pat_cnt_next = pat_cnt_reg;
        lat_cnt_next = lat_cnt_reg;
        clr          = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next   = S_SEED;
                    pat_cnt_next = '0;
                    clr          = 1'b1;
                end
            end
            S_SEED: begin
                state_next   = S_RUN;
                pat_cnt_next = '0;
            end
            S_RUN: begin
                if (pat_cnt_reg == PAT_W'(N_PAT - 1)) begin
                    state_next   = S_DRAIN;
                    lat_cnt_next = '0;
                end else begin
                    pat_cnt_next = pat_cnt_reg + PAT_W'(1);
                end
            end
            S_DRAIN: begin
                if (lat_cnt_reg == LAT_W'(LAT - 1)) begin
                    state_next = S_DONE;
                end else begin
                    lat_cnt_next = lat_cnt_reg + LAT_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control outputs are pure decodes of the state register, so no input
    // can reach an output combinationally.
    assign tpg_load  = (state_reg == S_SEED);
    assign tpg_en    = (state_reg == S_RUN);
    assign busy      = (state_reg == S_SEED) || (state_reg == S_RUN) ||
                       (state_reg == S_DRAIN);
    assign bist_mode = busy;
    assign done      = (state_reg == S_DONE);
    assign pass      = done && (fail_cnt_reg == '0);

    // ------------------------------------------------------------------
    // Sample-valid pipeline: tracks each TPG step through the LAT-cycle
    // CUT/ORA latency so ora_res is only looked at when it belongs to a
    // pattern of this run.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg[0] <= 1'b0;
        end else begin
            vld_reg[0] <= tpg_en;
        end
    end

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_vld
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_reg[gi] <= 1'b0;
                end else begin
                    vld_reg[gi] <= vld_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sample = vld_reg[LAT-1];

    // ------------------------------------------------------------------
    // Result collector
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt_reg   <= '0;
            first_fail_reg <= '1;
            smp_idx_reg    <= '0;
        end else if (clr) begin
            fail_cnt_reg   <= '0;
            first_fail_reg <= '1;
            smp_idx_reg    <= '0;
        end else if (sample) begin
            smp_idx_reg <= smp_idx_reg + CNT_W'(1);
            if (ora_res) begin
                // The two updates are independent: a saturated count does
                // not block first-fail capture and vice versa.
                if (fail_cnt_reg != '1) begin
                    fail_cnt_reg <= fail_cnt_reg + CNT_W'(1);
                end
                // All-ones cannot be a real index since N_PAT < 2**CNT_W.
                if (first_fail_reg == '1) begin
                    first_fail_reg <= smp_idx_reg;
                end
            end
        end
    end

    assign fail_cnt   = fail_cnt_reg;
    assign first_fail = first_fail_reg;

endmodule

// File: tb/tb_bist_ctrl.sv
// tb_bist_ctrl: directed, table-driven bench for bist_ctrl. Three instances
// cover the default configuration, CNT_W=4 and LAT=3.
module tb_bist_ctrl;

    localparam int N = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start_0, start_1, start_2;
    logic ora_0, ora_1, ora_2;
    logic tl_0, te_0, bm_0, busy_0, done_0, pass_0;
    logic tl_1, te_1, bm_1, busy_1, done_1, pass_1;
    logic tl_2, te_2, bm_2, busy_2, done_2, pass_2;
    logic [7:0] fc_0, ff_0, fc_2, ff_2;
    logic [3:0] fc_1, ff_1;

    bist_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start_0), .ora_res(ora_0),
        .tpg_load(tl_0), .tpg_en(te_0), .bist_mode(bm_0), .busy(busy_0),
        .done(done_0), .pass(pass_0), .fail_cnt(fc_0), .first_fail(ff_0)
    );

    bist_ctrl #(.BIT(4), .N_PAT(15), .LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start_1), .ora_res(ora_1),
        .tpg_load(tl_1), .tpg_en(te_1), .bist_mode(bm_1), .busy(busy_1),
        .done(done_1), .pass(pass_1), .fail_cnt(fc_1), .first_fail(ff_1)
    );

    bist_ctrl #(.BIT(4), .N_PAT(15), .LAT(3), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .start(start_2), .ora_res(ora_2),
        .tpg_load(tl_2), .tpg_en(te_2), .bist_mode(bm_2), .busy(busy_2),
        .done(done_2), .pass(pass_2), .fail_cnt(fc_2), .first_fail(ff_2)
    );

    // Outputs of the instance under test, widened to 8 bits.
    int sel;
    logic tl, te, bm, busy, done, pass;
    logic [7:0] fc, ff;
    always_comb begin
        tl = tl_0; te = te_0; bm = bm_0; busy = busy_0; done = done_0;
        pass = pass_0; fc = fc_0; ff = ff_0;
        case (sel)
            1: begin
                tl = tl_1; te = te_1; bm = bm_1; busy = busy_1; done = done_1;
                pass = pass_1; fc = {4'h0, fc_1}; ff = {4'h0, ff_1};
            end
            2: begin
                tl = tl_2; te = te_2; bm = bm_2; busy = busy_2; done = done_2;
                pass = pass_2; fc = fc_2; ff = ff_2;
            end
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic st, input logic o);
        start_0 = (s == 0) ? st : 1'b0;
        start_1 = (s == 1) ? st : 1'b0;
        start_2 = (s == 2) ? st : 1'b0;
        ora_0   = (s == 0) ? o : 1'b0;
        ora_1   = (s == 1) ? o : 1'b0;
        ora_2   = (s == 2) ? o : 1'b0;
    endtask

    typedef struct {
        int          sel;
        logic [14:0] mask;      // ora_res per sample index
        logic        oow;       // ora_res outside the sample window
        logic        start_mid; // extra start pulse in the middle of RUN
        logic [7:0]  exp_fc;
        logic [7:0]  exp_ff;
        logic        exp_pass;
    } vec_t;

    vec_t vecs[7];

    // Runs one BIST pass. Called #1 after a rising edge; returns likewise.
    task automatic run_vec(input int id, input vec_t v);
        int   lat;
        int   te_count;
        int   done_j;
        int   bad_j;
        int   k;
        logic [7:0] allones;
        logic st, o;
        lat     = (v.sel == 2) ? 3 : 1;
        allones = (v.sel == 1) ? 8'h0F : 8'hFF;
        sel     = v.sel;
        drive(v.sel, 1'b1, v.oow);
        @(posedge clk); #1;                 // edge E
        te_count = 0;
        done_j   = -1;
        bad_j    = -1;
        for (int j = 1; j <= N + lat + 6; j++) begin
            if (j == 1) begin
                chk($sformatf("v%0d clear_fail_cnt", id), fc, 8'h00);
                chk($sformatf("v%0d clear_first_fail", id), ff, allones);
            end
            if (bad_j < 0 &&
                (tl   !== (j == 1) ||
                 te   !== (j >= 2 && j <= 1 + N) ||
                 busy !== (j <= 1 + N + lat) ||
                 bm   !== (j <= 1 + N + lat) ||
                 done !== (j >= 2 + N + lat)))
                bad_j = j;
            if (te === 1'b1) te_count++;
            if (done === 1'b1 && done_j < 0) done_j = j;
            st = v.start_mid && (j == 9);
            k  = j - 2 - lat;
            o  = (k >= 0 && k < N) ? v.mask[k] : v.oow;
            drive(v.sel, st, o);
            @(posedge clk); #1;
        end
        drive(v.sel, 1'b0, 1'b0);
        chk($sformatf("v%0d schedule(first bad cycle %0d)", id, bad_j), 8'(bad_j), 8'hFF);
        chk($sformatf("v%0d tpg_en_count", id), 8'(te_count), 8'(N));
        chk($sformatf("v%0d done_cycle", id), 8'(done_j), 8'(2 + N + lat));
        chk($sformatf("v%0d fail_cnt", id), fc, v.exp_fc);
        chk($sformatf("v%0d first_fail", id), ff, v.exp_ff);
        chk($sformatf("v%0d pass", id), 8'(pass), 8'(v.exp_pass));
        $display("vec %0d sel=%0d mask=%h fail_cnt=%0d first_fail=%0h pass=%0b",
                 id, v.sel, v.mask, fc, ff, pass);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " tpg_load"},   8'(tl),   8'h00);
        chk({tag, " tpg_en"},     8'(te),   8'h00);
        chk({tag, " bist_mode"},  8'(bm),   8'h00);
        chk({tag, " busy"},       8'(busy), 8'h00);
        chk({tag, " done"},       8'(done), 8'h00);
        chk({tag, " pass"},       8'(pass), 8'h00);
        chk({tag, " fail_cnt"},   fc,       8'h00);
        chk({tag, " first_fail"}, ff,       8'hFF);
    endtask

    initial begin
        //            sel mask      oow   mid   fc     ff     pass
        vecs[0] = '{0, 15'h0008, 1'b0, 1'b1, 8'd1,  8'd3,  1'b0};
        vecs[1] = '{0, 15'h0000, 1'b0, 1'b0, 8'd0,  8'hFF, 1'b1};
        vecs[2] = '{0, 15'h4001, 1'b1, 1'b0, 8'd2,  8'd0,  1'b0};
        vecs[3] = '{0, 15'h2AAA, 1'b0, 1'b0, 8'd7,  8'd1,  1'b0};
        vecs[4] = '{1, 15'h7FFF, 1'b1, 1'b0, 8'd15, 8'd0,  1'b0};
        vecs[5] = '{2, 15'h4000, 1'b0, 1'b0, 8'd1,  8'd14, 1'b0};
        vecs[6] = '{2, 15'h7FFF, 1'b1, 1'b0, 8'd15, 8'd0,  1'b0};

        sel = 0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        rst = 1'b0;
        // ora_res toggling in IDLE must not be counted.
        drive(0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0);
        chk_reset_outputs("idle");
        $display("reset/idle checked");

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Saturated CNT_W=4 instance held in DONE with ora_res=1 stays at 15.
        sel = 1;
        drive(1, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0);
        chk("sat_hold fail_cnt", fc, 8'd15);
        chk("sat_hold first_fail", ff, 8'd0);
        $display("saturation hold fail_cnt=%0d", fc);

        // Reset in the middle of RUN (pattern 7) with failures already counted.
        sel = 0;
        drive(0, 1'b1, 1'b1);
        @(posedge clk); #1;                 // edge E
        drive(0, 1'b0, 1'b1);
        repeat (8) @(posedge clk);          // now in cycle E+9: pattern 7
        #1;
        chk("mid_run tpg_en", 8'(te), 8'h01);
        chk("mid_run fail_cnt", fc, 8'd6);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0);
        $display("mid-run reset checked");
        run_vec(7, vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
